// File: rtl/alu_exec_ctrl.sv
// Sequencer and register-file stage around a combinational ALU.
// Runs IDLE -> READ -> EXEC -> WB for each instruction and also accepts direct register loads while IDLE.
module alu_exec_ctrl #(
  parameter int unsigned DW    = 8,
  parameter int unsigned FW    = 8,
  parameter int unsigned NREGS = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic          ld_en,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [3:0]    ALU_CTL,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  input  logic [DW-1:0] Z,
  input  logic [FW-1:0] FLAGS,
  output logic [FW-1:0] flags_q,
  output logic          wb_done,
  output logic [DW-1:0] wb_data,
  output logic          busy,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int unsigned OPW = 4;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  ir_op;
  logic [AW-1:0]   ir_rd, ir_rs1, ir_rs2;
  logic [DW-1:0]   rf [NREGS];
  logic [DW-1:0]   z_q;
  logic [FW-1:0]   fl_q;
  logic            instr_fire;
  logic            unused_instr_bits;

  // The low three instruction bits are reserved and are ignored.
  assign unused_instr_bits = ^instr[2:0];

  assign busy     = (state_q != IDLE);
  assign wb_data  = z_q;
  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake decode. A load takes priority over an instruction.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    ld_ready    = 1'b0;
    wb_done     = 1'b0;
    instr_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        ld_ready    = 1'b1;
        instr_ready = ~ld_en;
        if (!ld_en && instr_valid) begin
          instr_fire = 1'b1;
          state_d    = READ;
        end
      end
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB: begin
        wb_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Register file: direct load in IDLE, result write-back in WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else if (state_q == IDLE && ld_en) begin
      rf[ld_addr] <= ld_data;
    end else if (wb_done) begin
      rf[ir_rd] <= z_q;
    end
  end

  // Instruction register, ALU operand drive, result capture and flag commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_op   <= '0;
      ir_rd   <= '0;
      ir_rs1  <= '0;
      ir_rs2  <= '0;
      ALU_CTL <= '0;
      A       <= '0;
      B       <= '0;
      z_q     <= '0;
      fl_q    <= '0;
      flags_q <= '0;
    end else begin
      if (instr_fire) begin
        ir_op  <= instr[15:12];
        ir_rd  <= AW'(instr[11:9]);
        ir_rs1 <= AW'(instr[8:6]);
        ir_rs2 <= AW'(instr[5:3]);
      end
      if (state_q == READ) begin
        A       <= rf[ir_rs1];
        B       <= rf[ir_rs2];
        ALU_CTL <= ir_op;
      end
      if (state_q == EXEC) begin
        z_q  <= Z;
        fl_q <= FLAGS;
      end
      if (wb_done) flags_q <= fl_q;
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl using an XOR ALU stub: Z = A ^ B, FLAGS = {4'h0, ALU_CTL}.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid, instr_ready;
  logic [15:0] instr;
  logic        ld_en, ld_ready;
  logic [2:0]  ld_addr;
  logic [7:0]  ld_data;
  logic [3:0]  ALU_CTL;
  logic [7:0]  A, B, Z;
  logic [7:0]  FLAGS, flags_q;
  logic        wb_done;
  logic [7:0]  wb_data;
  logic        busy;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_vec = 0;
  int n_err = 0;

  alu_exec_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_en(ld_en), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ALU_CTL(ALU_CTL), .A(A), .B(B), .Z(Z), .FLAGS(FLAGS),
    .flags_q(flags_q), .wb_done(wb_done), .wb_data(wb_data), .busy(busy),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  assign Z     = A ^ B;
  assign FLAGS = {4'h0, ALU_CTL};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic do_load(input logic [2:0] addr, input logic [7:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    tick();
    ld_en   = 1'b0;
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 3'b000};
  endfunction

  // Offer an instruction, wait (bounded) for ready, and leave the clock just past the accept edge.
  task automatic issue(input logic [15:0] ins);
    instr_valid = 1'b1;
    instr       = ins;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (instr_ready) break;
      tick();
    end
    chk("issue_ready", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  // Full instruction with operand, write-back and commit checks.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic [7:0] ea,
                           input logic [7:0] eb, input logic [2:0] rd);
    issue(ins);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_A"}, 32'(A), 32'(ea));
    chk({tag, "_B"}, 32'(B), 32'(eb));
    chk({tag, "_ctl"}, 32'(ALU_CTL), 32'(ins[15:12]));
    tick();
    chk({tag, "_wb_done"}, 32'(wb_done), 32'd1);
    chk({tag, "_wb_data"}, 32'(wb_data), 32'(ea ^ eb));
    tick();
    chk({tag, "_wb_drop"}, 32'(wb_done), 32'd0);
    chk({tag, "_flags"}, 32'(flags_q), {28'h0, ins[15:12]});
    peek({tag, "_rd"}, rd, ea ^ eb);
  endtask

  int         acc_cyc [3];
  int         k, n_acc, n_wb;
  logic [15:0] prog [3];

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wb_done", 32'(wb_done), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: reset state
    for (int r = 0; r < 8; r++) peek("rst_rf", 3'(r), 8'h00);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_flags", 32'(flags_q), 32'd0);
    chk("rst_ctl", 32'(ALU_CTL), 32'd0);

    // 2: basic op
    do_load(3'd1, 8'h3C);
    do_load(3'd2, 8'h0F);
    peek("ld_r1", 3'd1, 8'h3C);
    run_instr("op5", mk(4'h5, 3'd3, 3'd1, 3'd2), 8'h3C, 8'h0F, 3'd3);
    chk("hold_A", 32'(A), 32'h3C);

    // 3: rd == rs1 reads the pre-write value
    run_instr("rdrs1", mk(4'h5, 3'd1, 3'd1, 3'd2), 8'h3C, 8'h0F, 3'd1);
    // rs1 == rs2 gives A == B
    run_instr("same", mk(4'h2, 3'd5, 3'd2, 3'd2), 8'h0F, 8'h0F, 3'd5);

    // 4: load beats instruction; busy ignores ld_en/instr_valid
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 8'hA5;
    instr_valid = 1'b1; instr = mk(4'h3, 3'd7, 3'd6, 3'd2);
    #1;
    chk("prio_instr_ready", 32'(instr_ready), 32'd0);
    chk("prio_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_en = 1'b0;
    chk("prio_not_busy", 32'(busy), 32'd0);
    peek("prio_r6", 3'd6, 8'hA5);
    chk("prio_ready_after", 32'(instr_ready), 32'd1);
    tick();
    ld_en = 1'b1; ld_addr = 3'd0; ld_data = 8'hFF;
    #1;
    chk("busy_ld_ready", 32'(ld_ready), 32'd0);
    chk("busy_instr_ready", 32'(instr_ready), 32'd0);
    tick();
    chk("prio_A", 32'(A), 32'hA5);
    chk("prio_B", 32'(B), 32'h0F);
    tick();
    ld_en = 1'b0; instr_valid = 1'b0;
    chk("prio_wb_data", 32'(wb_data), 32'hAA);
    tick();
    chk("prio_idle", 32'(busy), 32'd0);
    peek("prio_r7", 3'd7, 8'hAA);
    peek("busy_ld_ignored", 3'd0, 8'h00);
    chk("prio_flags", 32'(flags_q), 32'h03);

    // 5: reset during EXEC aborts the instruction
    issue(mk(4'h9, 3'd4, 3'd1, 3'd2));
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_flags", 32'(flags_q), 32'd0);
    peek("abort_r4", 3'd4, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    peek("abort_r4_late", 3'd4, 8'h00);
    chk("abort_flags_late", 32'(flags_q), 32'd0);
    chk("abort_wb_done", 32'(wb_done), 32'd0);

    // 6: back-to-back issue, dependent chain
    do_load(3'd1, 8'h3C);
    do_load(3'd2, 8'h0F);
    prog[0] = mk(4'h1, 3'd3, 3'd1, 3'd2);  // r3 = 33
    prog[1] = mk(4'h2, 3'd4, 3'd3, 3'd1);  // r4 = 33^3C = 0F
    prog[2] = mk(4'h7, 3'd5, 3'd4, 3'd1);  // r5 = 0F^3C = 33
    k = 0; n_acc = 0; n_wb = 0;
    for (int c = 0; c < 16; c++) begin
      instr_valid = (k < 3);
      instr       = prog[(k < 3) ? k : 2];
      #1;
      if (wb_done) n_wb++;
      if (instr_valid && instr_ready) begin
        acc_cyc[k] = c;
        k++;
        n_acc++;
      end
      tick();
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_wb_pulses", 32'(n_wb), 32'd3);
    chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    peek("b2b_r3", 3'd3, 8'h33);
    peek("b2b_r4", 3'd4, 8'h0F);
    peek("b2b_r5", 3'd5, 8'h33);
    chk("b2b_flags", 32'(flags_q), 32'h07);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
